// File: rtl/bus_responder_8008_pkg.sv
// -----------------------------------------------------------------------------
// bus_responder_8008_pkg
// Shared types and defaults for the 8008 bus responder:
//   state_t           - core T-state as reported by the 8008 core
//   cycle_type_t      - cycle type carried in D[7:6] during T2
//   bus_resp_state_t  - read-side sequencer states
//   rd_src_t          - where the data for a read-like cycle comes from
// plus small decode helpers for the T2 control byte.
// -----------------------------------------------------------------------------
package bus_responder_8008_pkg;

    localparam int         WIDTH_DEF      = 8;
    localparam int         ADDR_WIDTH_DEF = 14;
    localparam logic [7:0] INTR_INSTR_DEF = 8'h05;   // RST 0

    typedef enum logic [2:0] {
        T1      = 3'd0,
        T1I     = 3'd1,
        T2      = 3'd2,
        WAIT    = 3'd3,
        T3      = 3'd4,
        T4      = 3'd5,
        T5      = 3'd6,
        STOPPED = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCR = 2'b01,
        PCC = 2'b10,
        PCW = 2'b11
    } cycle_type_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_RD_REQ  = 2'd1,
        R_RD_HOLD = 2'd2
    } bus_resp_state_t;

    typedef enum logic [1:0] {
        SRC_MEM  = 2'd0,
        SRC_INTR = 2'd1,
        SRC_INP  = 2'd2
    } rd_src_t;

    // Cycle type encoded in the top two bits of the T2 byte.
    function automatic cycle_type_t t2_cycle_type(input logic [7:0] d);
        return cycle_type_t'(d[7:6]);
    endfunction

    // A PCC cycle is an OUT when the T2 byte has a non-zero D[5:4].
    function automatic logic t2_is_out(input logic [7:0] d);
        return (cycle_type_t'(d[7:6]) == PCC) && (d[5:4] != 2'b00);
    endfunction

    // A PCC cycle is an INP when D[5:4] is zero.
    function automatic logic t2_is_inp(input logic [7:0] d);
        return (cycle_type_t'(d[7:6]) == PCC) && (d[5:4] == 2'b00);
    endfunction

endpackage

// File: rtl/bus_responder_8008_wr_post_buf.sv
// -----------------------------------------------------------------------------
// bus_responder_8008_wr_post_buf
// One-entry posted write buffer. A PCW cycle drops its data here at T3 and
// the core continues; the buffer then owns the memory port (mem_we=1) until
// mem_ack drains it. While it holds an entry the read path is not granted
// the port, so a read can never overtake a posted write.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   load_i           capture addr_i/data_i (only issued while empty)
//   addr_i, data_i   write address and data
//   mem_ack_i        memory completion pulse
//   req_o            write request towards memory (also mem_we)
//   addr_o, data_o   buffered address / data
//   empty_o          no write pending
//   rd_grant_o       read path may use the memory port
// -----------------------------------------------------------------------------
module bus_responder_8008_wr_post_buf
    import bus_responder_8008_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  mem_ack_i,
    output logic                  req_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  empty_o,
    output logic                  rd_grant_o
);

    logic                  full_q, full_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      data_q, data_d;

    // Buffer occupancy: fill on load, drain on the ack of our own request.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        data_d = data_q;
        if (load_i) begin
            full_d = 1'b1;
            addr_d = addr_i;
            data_d = data_i;
        end else if (full_q && mem_ack_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            addr_q <= {ADDR_WIDTH{1'b0}};
            data_q <= {WIDTH{1'b0}};
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign req_o      = full_q;
    assign addr_o     = addr_q;
    assign data_o     = data_q;
    assign empty_o    = ~full_q;
    assign rd_grant_o = ~full_q;

endmodule

// File: rtl/bus_responder_8008.sv
// -----------------------------------------------------------------------------
// bus_responder_8008
// External-side responder for the 8008 multiplexed bus. Captures the address
// and cycle type from T1/T2, serves memory reads (PCI/PCR) and posted writes
// (PCW) over a req/ack memory port, serves I/O (PCC) over simple port
// interfaces, and paces the core by driving Ready.
// Ports:
//   clk, rst_n                  clock (one T-state per clk), async reset
//   state, cpu_d                core T-state and core data out
//   cpu_din                     data to core (non-zero only in T3 of a read/INP)
//   Ready                       core Ready
//   mem_req/we/addr/wdata       memory request, held until mem_ack
//   mem_rdata, mem_ack          memory read data and completion pulse
//   io_out_stb/port/data        output port strobe with held port/data
//   io_in_port, io_in_data      input port select and sampled data
// -----------------------------------------------------------------------------
module bus_responder_8008
    import bus_responder_8008_pkg::*;
#(
    parameter int                WIDTH      = WIDTH_DEF,
    parameter int                ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [WIDTH-1:0]  INTR_INSTR = INTR_INSTR_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  state_t                state,
    input  logic [WIDTH-1:0]      cpu_d,
    output logic [WIDTH-1:0]      cpu_din,
    output logic                  Ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic                  io_out_stb,
    output logic [4:0]            io_out_port,
    output logic [WIDTH-1:0]      io_out_data,
    output logic [2:0]            io_in_port,
    input  logic [WIDTH-1:0]      io_in_data
);

    localparam int HI_W = ADDR_WIDTH - WIDTH;

    // Bus capture
    logic [WIDTH-1:0]  addr_lo_q, addr_lo_d;
    logic [HI_W-1:0]   addr_hi_q, addr_hi_d;
    cycle_type_t       ctype_q, ctype_d;
    logic              intr_fetch_q, intr_fetch_d;

    // Read sequencer
    bus_resp_state_t   fsm_q, fsm_d;
    rd_src_t           src_q, src_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic              rdy_q, rdy_d;
    logic              wr_wait_q, wr_wait_d;

    // I/O
    logic [2:0]        io_in_port_q, io_in_port_d;
    logic              io_out_stb_q, io_out_stb_d;
    logic [4:0]        io_out_port_q, io_out_port_d;
    logic [WIDTH-1:0]  io_out_data_q, io_out_data_d;

    // Write buffer interface
    logic                  wb_load_s;
    logic                  wb_req_s;
    logic [ADDR_WIDTH-1:0] wb_addr_s;
    logic [WIDTH-1:0]      wb_data_s;
    logic                  wb_empty_s;
    logic                  rd_grant_s;

    logic                  rd_req_s;
    logic                  fast_ok_s;
    logic                  t2_s;
    logic                  t3_s;

    assign t2_s = (state == T2);
    assign t3_s = (state == T3);

    // A read drives the port only once any posted write has drained.
    assign rd_req_s = (fsm_q == R_RD_REQ) && (src_q == SRC_MEM) && rd_grant_s;

    // Zero-wait T2: a PCW that can post immediately, or any OUT.
    assign fast_ok_s = t2_s &&
                       (((t2_cycle_type(cpu_d) == PCW) && wb_empty_s) ||
                        t2_is_out(cpu_d));

    bus_responder_8008_wr_post_buf #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_post_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (wb_load_s),
        .addr_i     ({addr_hi_q, addr_lo_q}),
        .data_i     (cpu_d),
        .mem_ack_i  (mem_ack),
        .req_o      (wb_req_s),
        .addr_o     (wb_addr_s),
        .data_o     (wb_data_s),
        .empty_o    (wb_empty_s),
        .rd_grant_o (rd_grant_s)
    );

    // Next-state logic: address capture, read sequencer, I/O, write pacing.
    always_comb begin
        addr_lo_d     = addr_lo_q;
        addr_hi_d     = addr_hi_q;
        ctype_d       = ctype_q;
        intr_fetch_d  = intr_fetch_q;
        fsm_d         = fsm_q;
        src_d         = src_q;
        hold_d        = hold_q;
        rdy_d         = rdy_q;
        wr_wait_d     = wr_wait_q;
        io_in_port_d  = io_in_port_q;
        io_out_stb_d  = 1'b0;
        io_out_port_d = io_out_port_q;
        io_out_data_d = io_out_data_q;
        wb_load_s     = 1'b0;

        // Low address byte and interrupt-acknowledge flag come from T1/T1I.
        if ((state == T1) || (state == T1I)) begin
            addr_lo_d    = cpu_d;
            intr_fetch_d = (state == T1I);
        end else begin
            addr_lo_d    = addr_lo_q;
        end

        // High address bits and cycle type come from T2.
        if (t2_s) begin
            addr_hi_d = cpu_d[HI_W-1:0];
            ctype_d   = t2_cycle_type(cpu_d);
        end else begin
            addr_hi_d = addr_hi_q;
        end

        case (fsm_q)
            R_IDLE: begin
                if (t2_s) begin
                    case (t2_cycle_type(cpu_d))
                        PCI, PCR: begin
                            fsm_d = R_RD_REQ;
                            if ((t2_cycle_type(cpu_d) == PCI) && intr_fetch_q) begin
                                src_d = SRC_INTR;
                            end else begin
                                src_d = SRC_MEM;
                            end
                        end
                        PCC: begin
                            if (t2_is_inp(cpu_d)) begin
                                fsm_d        = R_RD_REQ;
                                src_d        = SRC_INP;
                                io_in_port_d = cpu_d[3:1];
                            end else begin
                                // OUT: the accumulator went out at T1, the port at T2.
                                io_out_stb_d  = 1'b1;
                                io_out_port_d = cpu_d[5:1];
                                io_out_data_d = addr_lo_q;
                            end
                        end
                        PCW: begin
                            // Buffer still draining: hold the core in WAIT.
                            if (!wb_empty_s) begin
                                wr_wait_d = 1'b1;
                            end else begin
                                wr_wait_d = 1'b0;
                            end
                        end
                        default: begin
                            fsm_d = R_IDLE;
                        end
                    endcase
                end else if (t3_s && (ctype_q == PCW)) begin
                    // Post the write; the core is released without waiting for memory.
                    wb_load_s = wb_empty_s;
                    rdy_d     = 1'b0;
                end else begin
                    fsm_d = R_IDLE;
                end
            end

            R_RD_REQ: begin
                case (src_q)
                    SRC_INTR: begin
                        hold_d = INTR_INSTR;
                        rdy_d  = 1'b1;
                        fsm_d  = R_RD_HOLD;
                    end
                    SRC_INP: begin
                        hold_d = io_in_data;
                        rdy_d  = 1'b1;
                        fsm_d  = R_RD_HOLD;
                    end
                    SRC_MEM: begin
                        if (rd_req_s && mem_ack) begin
                            hold_d = mem_rdata;
                            rdy_d  = 1'b1;
                            fsm_d  = R_RD_HOLD;
                        end else begin
                            fsm_d  = R_RD_REQ;
                        end
                    end
                    default: begin
                        fsm_d = R_IDLE;
                    end
                endcase
            end

            R_RD_HOLD: begin
                if (t3_s) begin
                    rdy_d = 1'b0;
                    fsm_d = R_IDLE;
                end else begin
                    fsm_d = R_RD_HOLD;
                end
            end

            default: begin
                fsm_d = R_IDLE;
            end
        endcase

        // Release a PCW that stalled on a full buffer once the buffer is empty.
        if (wr_wait_q && wb_empty_s) begin
            rdy_d     = 1'b1;
            wr_wait_d = 1'b0;
        end else begin
            wr_wait_d = wr_wait_d;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q     <= {WIDTH{1'b0}};
            addr_hi_q     <= {HI_W{1'b0}};
            ctype_q       <= PCI;
            intr_fetch_q  <= 1'b0;
            fsm_q         <= R_IDLE;
            src_q         <= SRC_MEM;
            hold_q        <= {WIDTH{1'b0}};
            rdy_q         <= 1'b0;
            wr_wait_q     <= 1'b0;
            io_in_port_q  <= 3'd0;
            io_out_stb_q  <= 1'b0;
            io_out_port_q <= 5'd0;
            io_out_data_q <= {WIDTH{1'b0}};
        end else begin
            addr_lo_q     <= addr_lo_d;
            addr_hi_q     <= addr_hi_d;
            ctype_q       <= ctype_d;
            intr_fetch_q  <= intr_fetch_d;
            fsm_q         <= fsm_d;
            src_q         <= src_d;
            hold_q        <= hold_d;
            rdy_q         <= rdy_d;
            wr_wait_q     <= wr_wait_d;
            io_in_port_q  <= io_in_port_d;
            io_out_stb_q  <= io_out_stb_d;
            io_out_port_q <= io_out_port_d;
            io_out_data_q <= io_out_data_d;
        end
    end

    assign Ready       = rdy_q | fast_ok_s;
    assign cpu_din     = ((fsm_q == R_RD_HOLD) && t3_s) ? hold_q : {WIDTH{1'b0}};
    assign mem_req     = wb_req_s | rd_req_s;
    assign mem_we      = wb_req_s;
    assign mem_addr    = wb_req_s ? wb_addr_s : {addr_hi_q, addr_lo_q};
    assign mem_wdata   = wb_data_s;
    assign io_out_stb  = io_out_stb_q;
    assign io_out_port = io_out_port_q;
    assign io_out_data = io_out_data_q;
    assign io_in_port  = io_in_port_q;

endmodule

// File: tb/tb_bus_responder_8008.sv
// -----------------------------------------------------------------------------
// tb_bus_responder_8008
// Core-side driver plays the 8008 bus protocol; a memory model answers
// requests with variable latency; expectations are queued at issue time and
// a monitor compares them as the DUT presents requests, strobes and data.
// -----------------------------------------------------------------------------
module tb_bus_responder_8008;
    import bus_responder_8008_pkg::*;

    localparam int K_RD  = 0;
    localparam int K_PCI = 1;
    localparam int K_INT = 2;
    localparam int K_WR  = 3;
    localparam int K_OUT = 4;
    localparam int K_INP = 5;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n;
    state_t      state;
    logic [7:0]  cpu_d, cpu_din, mem_wdata, mem_rdata, io_out_data, io_in_data;
    logic        Ready, mem_req, mem_we, mem_ack, io_out_stb;
    logic [13:0] mem_addr;
    logic [4:0]  io_out_port;
    logic [2:0]  io_in_port;

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [0:16383];
    logic [7:0] dev_mem [0:16383];
    req_t       exp_req_q [$];
    logic [7:0] exp_din_q [$];
    logic [12:0] exp_out_q [$];
    logic       wb_pend_m = 1'b0;
    int         lat_cfg = 0;
    logic       inject_ack = 1'b0;

    bus_responder_8008 dut (
        .clk(clk), .rst_n(rst_n), .state(state), .cpu_d(cpu_d), .cpu_din(cpu_din),
        .Ready(Ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .io_out_stb(io_out_stb), .io_out_port(io_out_port), .io_out_data(io_out_data),
        .io_in_port(io_in_port), .io_in_data(io_in_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // Memory device: acks after lat_cfg cycles (random 1..4 when 0).
    initial begin : memory_device
        int dcnt, dlat;
        logic dwe_last;
        mem_ack = 1'b0; mem_rdata = 8'h00; dcnt = 0; dlat = 1; dwe_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_ack && dwe_last) wb_pend_m = 1'b0;
            mem_ack = 1'b0;
            if (!rst_n) begin
                dcnt = 0;
            end else if (inject_ack) begin
                mem_ack = 1'b1; mem_rdata = 8'hEE; dwe_last = 1'b0; inject_ack = 1'b0;
            end else if (mem_req) begin
                if (dcnt == 0) dlat = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
                dcnt++;
                if (dcnt >= dlat) begin
                    mem_ack = 1'b1; dwe_last = mem_we; dcnt = 0;
                    if (mem_we) dev_mem[mem_addr] = mem_wdata;
                    else        mem_rdata = dev_mem[mem_addr];
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin : monitor
        logic        req_live;
        logic        cur_we;
        logic [13:0] cur_addr;
        req_t        r;
        logic [12:0] o;
        req_live = 1'b0; cur_we = 1'b0; cur_addr = 14'h0;
        forever begin
            @(negedge clk); #2;
            if (!rst_n) begin
                req_live = 1'b0;
            end else begin
                if (mem_req && !req_live) begin
                    if (exp_req_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_req: got addr %h we %b expected none", mem_addr, mem_we);
                    end else begin
                        r = exp_req_q.pop_front();
                        chk("req_we", {31'd0, mem_we}, {31'd0, r.we});
                        chk("req_addr", {18'd0, mem_addr}, {18'd0, r.addr});
                        if (r.we) chk("req_wdata", {24'd0, mem_wdata}, {24'd0, r.data});
                    end
                    req_live = 1'b1; cur_we = mem_we; cur_addr = mem_addr;
                end else if (mem_req && req_live) begin
                    chk("req_stable", {17'd0, mem_we, mem_addr}, {17'd0, cur_we, cur_addr});
                end
                if (mem_ack) req_live = 1'b0;
                if (io_out_stb) begin
                    if (exp_out_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_stb: got port %h expected none", io_out_port);
                    end else begin
                        o = exp_out_q.pop_front();
                        chk("out_port_data", {19'd0, io_out_port, io_out_data}, {19'd0, o});
                    end
                end
                if (state == T3) begin
                    if (exp_din_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_t3: got cpu_din %h expected none", cpu_din);
                    end else begin
                        chk("cpu_din_t3", {24'd0, cpu_din}, {24'd0, exp_din_q.pop_front()});
                    end
                end else begin
                    chk("cpu_din_zero", {24'd0, cpu_din}, 32'd0);
                end
            end
        end
    end

    // One complete bus cycle as the core would run it; leaves time at posedge+1.
    task automatic bus_cycle(input int kind, input logic [13:0] addr, input logic [7:0] dat);
        logic [7:0] t2d, expd;
        logic       exp_rdy, waited;
        int         n;
        state = (kind == K_INT) ? T1I : T1;
        cpu_d = (kind == K_OUT) ? dat : addr[7:0];
        tick();
        case (kind)
            K_RD:         t2d = {2'b01, addr[13:8]};
            K_PCI, K_INT: t2d = {2'b00, addr[13:8]};
            K_WR:         t2d = {2'b11, addr[13:8]};
            K_OUT:        t2d = {2'b10, addr[13:8]};
            default:      t2d = {2'b10, 2'b00, addr[2:0], 1'b0};
        endcase
        expd = 8'h00;
        case (kind)
            K_RD, K_PCI: begin
                exp_req_q.push_back({1'b0, addr, 8'h00});
                expd = ref_mem[addr];
            end
            K_INT:   expd = 8'h05;
            K_INP:   begin io_in_data = dat; expd = dat; end
            K_OUT:   exp_out_q.push_back({t2d[5:1], dat});
            default: expd = 8'h00;
        endcase
        state = T2; cpu_d = t2d;
        settle();
        exp_rdy = ((kind == K_WR) && !wb_pend_m) || (kind == K_OUT);
        chk("ready_t2", {31'd0, Ready}, {31'd0, exp_rdy});
        n = 0; waited = 1'b0;
        while (Ready !== 1'b1 && n < 60) begin
            tick(); state = WAIT; cpu_d = 8'($urandom);
            settle(); n++; waited = 1'b1;
        end
        if (Ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got Ready %b expected 1 within 60 clks", Ready);
        end
        if (kind == K_WR && waited) chk("wr_ready_after_drain", {31'd0, wb_pend_m}, 32'd0);
        if (kind == K_INP) chk("io_in_port", {29'd0, io_in_port}, {29'd0, addr[2:0]});
        tick();
        exp_din_q.push_back(expd);
        state = T3;
        cpu_d = (kind == K_WR) ? dat : 8'($urandom);
        if (kind == K_WR) begin
            exp_req_q.push_back({1'b1, addr, dat});
            ref_mem[addr] = dat;
            wb_pend_m = 1'b1;
        end
        tick();
    endtask

    initial begin : stimulus
        int kind;
        logic [13:0] a;
        rst_n = 1'b0; state = STOPPED; cpu_d = 8'h00; io_in_data = 8'h00;
        for (int i = 0; i < 16384; i++) begin
            ref_mem[i] = 8'($urandom);
            dev_mem[i] = ref_mem[i];
        end
        #12;
        chk("rst_ready", {31'd0, Ready}, 32'd0);
        chk("rst_cpu_din", {24'd0, cpu_din}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_io_out_stb", {31'd0, io_out_stb}, 32'd0);
        tick(); rst_n = 1'b1;
        tick();

        // Directed read with 3-clk ack latency.
        ref_mem[14'h1234] = 8'hA7; dev_mem[14'h1234] = 8'hA7;
        lat_cfg = 3;
        bus_cycle(K_RD, 14'h1234, 8'h00);
        state = STOPPED; settle();
        chk("ready_after_t3", {31'd0, Ready}, 32'd0);
        tick();

        // Posted writes back to back, then a read that must follow the write.
        lat_cfg = 4;
        bus_cycle(K_WR, 14'h0010, 8'h5C);
        bus_cycle(K_WR, 14'h0011, 8'h3A);
        bus_cycle(K_RD, 14'h0011, 8'h00);
        lat_cfg = 0;

        // Interrupt fetch, OUT, INP.
        bus_cycle(K_INT, 14'h0123, 8'h00);
        bus_cycle(K_OUT, 14'h2600, 8'h99);
        bus_cycle(K_INP, 14'h0003, 8'h3C);

        // Reset during an outstanding read request.
        lat_cfg = 20;
        exp_req_q.push_back({1'b0, 14'h0456, 8'h00});
        state = T1; cpu_d = 8'h56; tick();
        state = T2; cpu_d = 8'h44; tick();
        state = WAIT; settle();
        chk("rd_req_before_rst", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_ready", {31'd0, Ready}, 32'd0);
        exp_req_q.delete(); exp_din_q.delete(); exp_out_q.delete();
        wb_pend_m = 1'b0; state = STOPPED;
        tick(); tick(); rst_n = 1'b1;
        inject_ack = 1'b1;
        lat_cfg = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("stray_ack_ready", {31'd0, Ready}, 32'd0);
            chk("stray_ack_req", {31'd0, mem_req}, 32'd0);
        end
        tick();
        bus_cycle(K_RD, 14'h0456, 8'h00);

        // Randomised traffic over a small address window to provoke hazards.
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 5));
            a = 14'($urandom_range(0, 31));
            if (kind == K_OUT) a = {2'($urandom_range(1, 3)), 4'($urandom), 8'($urandom)};
            bus_cycle(kind, a, 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                state = ($urandom_range(0, 1) == 0) ? T4 : T5;
                tick();
            end
        end

        state = STOPPED;
        repeat (20) tick();
        chk("drain_req_q", exp_req_q.size(), 32'd0);
        chk("drain_din_q", exp_din_q.size(), 32'd0);
        chk("drain_out_q", exp_out_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_responder_8008.md
Name: bus_responder_8008

Overview:
- External-side responder for the 8008 core's multiplexed bus.
- Watches the core's T-state and data output, and latches the 14-bit address and cycle type from T1/T2.
- Serves PCI/PCR reads and PCW writes against a request/ack memory port, and PCC I/O against simple port interfaces.
- Paces the core through WAIT by driving Ready. Sits between the core and memory/peripherals at SoC top level.

Parameters:
- WIDTH, 8, data bus width; only 8 is supported.
- ADDR_WIDTH, 14, memory address width.
- INTR_INSTR, 8'h05, instruction jammed on an interrupt-acknowledge fetch (RST 0).

Ports:
- clk  input  1  system clock; one core T-state per clk.
- rst_n  input  1  asynchronous, active-low reset.
- state  input  state_t  core T-state (T1, T1I, T2, WAIT, T3, T4, T5, STOPPED).
- cpu_d  input  WIDTH  core D_out.
- cpu_din  output  WIDTH  drives core D_in.
- Ready  output  1  to core Ready.
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  1 = write request.
- mem_addr  output  ADDR_WIDTH  request address.
- mem_wdata  output  WIDTH  write data.
- mem_rdata  input  WIDTH  read data, valid with mem_ack.
- mem_ack  input  1  one-clk completion pulse.
- io_out_stb  output  1  one-clk output-port strobe.
- io_out_port  output  5  output port number.
- io_out_data  output  WIDTH  output data.
- io_in_port  output  3  input port select.
- io_in_data  input  WIDTH  input port data, sampled.

Behaviour:
Reset:
- rst_n is asynchronous, active low.
- On reset: Ready=0, cpu_din=0, mem_req=0, mem_we=0, io_out_stb=0, all latches 0, write buffer empty, FSM R_IDLE.
- Reset mid-operation abandons any pending request: mem_req drops immediately, and a late mem_ack is ignored.

Address capture:
- In a clk with state T1 or T1I: addr_lo<=cpu_d, intr_fetch<=(state==T1I).
- In T2: addr_hi<=cpu_d[5:0], ctype<=cpu_d[7:6].
- Cycle types: 00 PCI, 01 PCR, 10 PCC, 11 PCW.
- mem_addr={addr_hi,addr_lo}.

Ready path:
- Ready = rdy_q OR fast_ok.
- fast_ok is combinational and true only while state==T2 and either:
  - cpu_d[7:6]==PCW and the write buffer is empty, or
  - cpu_d[7:6]==PCC with cpu_d[5:4]!=00 (OUT).
- Reads never pass T2 without at least one WAIT.

Read (PCI/PCR):
- FSM R_IDLE -> R_RD_REQ on T2.
- In R_RD_REQ, mem_req=1 and mem_we=0, but only once the write buffer is empty; reads never overtake a posted write.
- On mem_ack: hold<=mem_rdata, rdy_q<=1, go to R_RD_HOLD.
- In R_RD_HOLD: cpu_din=hold while state==T3. On the first T3 clk, rdy_q<=0 and return to R_IDLE.

Interrupt fetch:
- A PCI with intr_fetch=1 issues no memory request.
- hold<=INTR_INSTR and rdy_q<=1 the clk after T2.

Input (PCC with cpu_d[5:4]==00):
- io_in_port=cpu_d[3:1], registered at T2.
- hold<=io_in_data the clk after T2, then rdy_q<=1. This follows the same R_RD_HOLD path.

Output (PCC otherwise):
- The clk after T2: io_out_stb=1 for one clk, io_out_port=addr_hi[5:1], io_out_data=addr_lo (accumulator sent at T1).
- io_out_port and io_out_data hold until the next strobe.

Write (PCW):
- At T3: wbuf<=cpu_d, buffer full, latch address.
- Then mem_req=1, mem_we=1 until mem_ack, which empties the buffer.
- A PCW T2 while the buffer is still full gives fast_ok=0. The core waits; rdy_q<=1 the clk after the buffer empties.

cpu_din:
- Equals 0 outside T3 of a read or input cycle.

Robustness:
- T2 without a preceding T1 uses stale addr_lo; this is not an error.
- STOPPED, T4 and T5 are ignored.
- A mem_ack arriving with no request outstanding is ignored.

Decomposition:
- Shared package (internal_defines): cycle_type_t {PCI, PCR, PCC, PCW}; bus_resp_state_t {R_IDLE, R_RD_REQ, R_RD_HOLD}; localparam INTR_INSTR default. state_t is reused.
- One sub-module, wr_post_buf: one-entry posted write buffer owning the mem_we request/ack handshake. It exports empty and an arbitration grant to the read path.

Test Plan:
- PCR, addr 14'h1234 (T1 cpu_d=8'h34, T2 cpu_d=8'h52), mem_ack 3 clks after request with mem_rdata=8'hA7 -> mem_addr=14'h1234, Ready 0 in T2 and WAIT, Ready 1 after ack, cpu_din=8'hA7 in T3, Ready 0 after T3.
- PCW to 14'h0010, T3 cpu_d=8'h5C -> Ready 1 in T2 (fast path), mem_req/mem_we asserted after T3 with wdata 8'h5C. A second PCW T2 before ack -> Ready 0 until ack, then 1.
- PCW then immediate PCR to the same address -> read mem_req issued only after the write mem_ack (ordering).
- T1I fetch -> no mem_req, cpu_din=8'h05 in T3. OUT with T1 cpu_d=8'h99, T2 cpu_d=8'hA6 -> io_out_stb one clk, port 5'h13, data 8'h99, Ready 1 in T2.
- INP port 3 (T2 cpu_d=8'h86), io_in_data=8'h3C -> io_in_port=3, cpu_din=8'h3C in T3.
- rst_n low during R_RD_REQ -> mem_req 0 immediately, Ready 0. A mem_ack after reset release is ignored, and the next cycle proceeds normally.
